// File: rtl/sfr_bridge_pkg.sv
// rtl/sfr_bridge_pkg.sv - opcodes, FSM states and address step for the SFR byte-stream bridge
package sfr_bridge_pkg;

   localparam logic [1:0] OP_PING  = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_NEXT  = 2'b11;

   localparam logic [7:0] ADDR_STEP = 8'd2;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_DHI,
      ST_DLO,
      ST_BUS,
      ST_RHI,
      ST_RLO,
      ST_ACK
   } state_t;

   function automatic logic is_rx_state(input state_t s);
      return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DHI) || (s == ST_DLO);
   endfunction

   function automatic logic is_tx_state(input state_t s);
      return (s == ST_RHI) || (s == ST_RLO) || (s == ST_ACK);
   endfunction

endpackage

// File: rtl/sfr_bridge_if.sv
// rtl/sfr_bridge_if.sv - host byte channels plus SFR bus; master is the bridge, slave the host/responder side
interface sfr_bridge_if;

   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        sel;
   logic        r;
   logic [1:0]  w;
   logic [7:0]  addr;
   logic [15:0] dwrite;
   logic [15:0] sfr_data;
   logic        busy;

   modport master (
      input  rx_data, rx_valid, tx_ready, sfr_data,
      output rx_ready, tx_data, tx_valid, sel, r, w, addr, dwrite, busy
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, sfr_data,
      input  rx_ready, tx_data, tx_valid, sel, r, w, addr, dwrite, busy
   );

endinterface

// File: rtl/sfr_bridge_tx.sv
// rtl/sfr_bridge_tx.sv - response holding register: two-byte load, frozen while tx_valid & !tx_ready
module sfr_bridge_tx (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] load_hi,
   input  logic [7:0] load_lo,
   input  logic       shift,
   input  logic       valid,
   input  logic       ready,
   output logic       fire,
   output logic [7:0] tx_data
);

   logic [7:0] lo_q;
   logic       hold;

   assign fire = valid & ready;
   assign hold = valid & ~ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_data <= 8'h00;
         lo_q    <= 8'h00;
      end else if (!hold) begin
         if (load) begin
            tx_data <= load_hi;
            lo_q    <= load_lo;
         end else if (shift && fire) begin
            // high byte accepted: present the held low byte next
            tx_data <= lo_q;
         end
      end
   end

endmodule

// File: rtl/sfr_bridge.sv
// rtl/sfr_bridge.sv - byte-stream command decoder driving one-cycle SFR read/write bus cycles
// SFR_BRIDGE_AUTOINC_EN turns opcode 11 into read-next (addr += ADDR_STEP); otherwise it returns ERR_BYTE.
module sfr_bridge
   import sfr_bridge_pkg::*;
#(
   parameter logic [7:0] ACK_BYTE = 8'hA5,
   parameter logic [7:0] ERR_BYTE = 8'hEE
) (
   input  logic         clk,
   input  logic         reset,
   sfr_bridge_if.master bus
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] op_q;
   logic [1:0] mask_q;
   logic [1:0] cur_op;
   logic [1:0] cur_mask;
   logic       rx_fire;
   logic       tx_fire;
   logic       ld_cmd;
   logic       ld_addr;
   logic       inc_addr;
   logic       ld_dhi;
   logic       ld_dlo;
   logic       tx_load;
   logic       tx_shift;
   logic [7:0] tx_hi;
   logic [7:0] tx_lo;
   logic       bus_nxt;
   logic       unused_cmd_bits;

   assign bus.rx_ready = is_rx_state(state);
   assign bus.tx_valid = is_tx_state(state);
   assign bus.busy     = (state != ST_CMD);
   assign rx_fire      = bus.rx_valid & bus.rx_ready;

   // In CMD the opcode is still on rx_data; later states use the captured copy.
   assign cur_op   = (state == ST_CMD) ? bus.rx_data[7:6] : op_q;
   assign cur_mask = (state == ST_CMD) ? bus.rx_data[1:0] : mask_q;
   assign bus_nxt  = (state_nxt == ST_BUS);

   assign unused_cmd_bits = ^bus.rx_data[5:2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_CMD;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_cmd    = 1'b0;
      ld_addr   = 1'b0;
      inc_addr  = 1'b0;
      ld_dhi    = 1'b0;
      ld_dlo    = 1'b0;
      tx_load   = 1'b0;
      tx_shift  = 1'b0;
      tx_hi     = 8'h00;
      tx_lo     = 8'h00;
      case (state)
         ST_CMD: begin
            if (rx_fire) begin
               ld_cmd = 1'b1;
               case (bus.rx_data[7:6])
                  OP_PING: begin
                     state_nxt = ST_ACK;
                     tx_load   = 1'b1;
                     tx_hi     = ACK_BYTE;
                  end
                  OP_READ, OP_WRITE: state_nxt = ST_ADDR;
                  default: begin
`ifdef SFR_BRIDGE_AUTOINC_EN
                     inc_addr  = 1'b1;
                     state_nxt = ST_BUS;
`else
                     state_nxt = ST_ACK;
                     tx_load   = 1'b1;
                     tx_hi     = ERR_BYTE;
`endif
                  end
               endcase
            end
         end
         ST_ADDR: begin
            if (rx_fire) begin
               ld_addr   = 1'b1;
               state_nxt = (op_q == OP_WRITE) ? ST_DHI : ST_BUS;
            end
         end
         ST_DHI: begin
            if (rx_fire) begin
               ld_dhi    = 1'b1;
               state_nxt = ST_DLO;
            end
         end
         ST_DLO: begin
            if (rx_fire) begin
               ld_dlo    = 1'b1;
               state_nxt = ST_BUS;
            end
         end
         ST_BUS: begin
            tx_load = 1'b1;
            if (op_q == OP_WRITE) begin
               state_nxt = ST_ACK;
               tx_hi     = ACK_BYTE;
            end else begin
               // read data is sampled at the edge that ends the bus cycle
               state_nxt = ST_RHI;
               tx_hi     = bus.sfr_data[15:8];
               tx_lo     = bus.sfr_data[7:0];
            end
         end
         ST_RHI: begin
            tx_shift = 1'b1;
            if (tx_fire) state_nxt = ST_RLO;
         end
         ST_RLO: begin
            if (tx_fire) state_nxt = ST_CMD;
         end
         ST_ACK: begin
            if (tx_fire) state_nxt = ST_CMD;
         end
         default: state_nxt = ST_CMD;
      endcase
   end

   // Bus strobes are registered from the next state so they span exactly the BUS period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= 2'b00;
         mask_q     <= 2'b00;
         bus.addr   <= 8'h00;
         bus.dwrite <= 16'h0000;
         bus.sel    <= 1'b0;
         bus.r      <= 1'b0;
         bus.w      <= 2'b00;
      end else begin
         if (ld_cmd) begin
            op_q   <= bus.rx_data[7:6];
            mask_q <= bus.rx_data[1:0];
         end
         if (ld_addr)       bus.addr <= bus.rx_data;
         else if (inc_addr) bus.addr <= bus.addr + ADDR_STEP;
         if (ld_dhi) bus.dwrite[15:8] <= bus.rx_data;
         if (ld_dlo) bus.dwrite[7:0]  <= bus.rx_data;
         bus.sel <= bus_nxt;
         bus.r   <= bus_nxt && (cur_op != OP_WRITE);
         bus.w   <= (bus_nxt && (cur_op == OP_WRITE)) ? cur_mask : 2'b00;
      end
   end

   sfr_bridge_tx u_tx (
      .clk     (clk),
      .reset   (reset),
      .load    (tx_load),
      .load_hi (tx_hi),
      .load_lo (tx_lo),
      .shift   (tx_shift),
      .valid   (bus.tx_valid),
      .ready   (bus.tx_ready),
      .fire    (tx_fire),
      .tx_data (bus.tx_data)
   );

endmodule
